hazard_ctrl: RTL and testbench

Central pipeline hazard controller for the 5-stage MIPS32 core. It generates EX-stage forwarding selects, detects load-use hazards, and sequences branch resolution. It drives the resume handshake that releases the decode-stage branch stall. It sits beside the datapath, observing register indices and control bits of the D/E/M/W stages, and drives stall/flush/forward controls back into the pipeline registers.

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/hazard_ctrl_fwd_sel.sv | 23 ++
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard logic.
// Holds the hazard FSM states, forwarding select encodings and register-zero index.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    BRANCH_WAIT = 2'd1,
    FLUSH       = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register $zero is hard-wired, so a write to it never produces a usable value.
  function automatic logic live_write(input logic en, input logic [4:0] dst,
                                      input logic [4:0] src);
    return en && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX-stage operand forwarding select for a single ALU source.
// The M-stage result is newer than the W-stage result, so M wins when both match.
module fwd_sel
  import pipeline_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_w,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (live_write(reg_write_m, write_reg_m, src)) begin
      sel = FWD_M;
    end else if (live_write(reg_write_w, write_reg_w, src)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: EX forwarding, load-use stalls and branch resolution sequencing.
// Forwarding and load-use are same-cycle; branch actions follow the registered FSM state.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int BRANCH_TIMEOUT = 8,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             branch_d,
  input  logic [4:0]       rs_e,
  input  logic [4:0]       rt_e,
  input  logic [4:0]       write_reg_e,
  input  logic             reg_write_e,
  input  logic             mem_to_reg_e,
  input  logic [4:0]       write_reg_m,
  input  logic             reg_write_m,
  input  logic [4:0]       write_reg_w,
  input  logic             reg_write_w,
  input  logic             branch_resolved,
  input  logic             branch_taken,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             resume,
  output logic             redirect,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = ($clog2(BRANCH_TIMEOUT) > 0) ? $clog2(BRANCH_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BRANCH_TIMEOUT - 1);

  hz_state_t         state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        fwd_a_raw, fwd_b_raw;
  logic              lu;
  logic              timeout_set;

  fwd_sel u_fwd_a (
    .src         (rs_e),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .write_reg_w (write_reg_w),
    .reg_write_w (reg_write_w),
    .sel         (fwd_a_raw)
  );

  fwd_sel u_fwd_b (
    .src         (rt_e),
    .write_reg_m (write_reg_m),
    .reg_write_m (reg_write_m),
    .write_reg_w (write_reg_w),
    .reg_write_w (reg_write_w),
    .sel         (fwd_b_raw)
  );

  assign forward_a_e = rst ? FWD_REG : fwd_a_raw;
  assign forward_b_e = rst ? FWD_REG : fwd_b_raw;

  assign lu = mem_to_reg_e && reg_write_e && (write_reg_e != REG_ZERO) &&
              ((write_reg_e == rs_d) || (write_reg_e == rt_d));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Load-use outranks a branch in decode; the branch is picked up once the bubble is in.
  always_comb begin
    state_next  = state;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    resume      = 1'b0;
    redirect    = 1'b0;
    timeout_set = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else if (branch_d) begin
            state_next = BRANCH_WAIT;
          end
        end
        BRANCH_WAIT: begin
          stall_f = 1'b1;
          flush_d = 1'b1;
          if (branch_resolved) begin
            resume     = 1'b1;
            state_next = branch_taken ? FLUSH : RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            resume      = 1'b1;
            timeout_set = 1'b1;
            state_next  = RUN;
          end
        end
        FLUSH: begin
          redirect   = 1'b1;
          flush_d    = 1'b1;
          flush_e    = 1'b1;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != BRANCH_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (timeout_set) begin
      timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_f) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// Inputs change just after the rising edge; outputs are sampled 1ns later.
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic        branch_d, reg_write_e, mem_to_reg_e, reg_write_m, reg_write_w;
  logic        branch_resolved, branch_taken;
  logic        stall_f, stall_d, flush_d, flush_e, resume, redirect, timeout_err;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [31:0] stall_count;

  int checks;
  int errors;

  hazard_ctrl #(.BRANCH_TIMEOUT(8), .CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs_d            (rs_d),
    .rt_d            (rt_d),
    .branch_d        (branch_d),
    .rs_e            (rs_e),
    .rt_e            (rt_e),
    .write_reg_e     (write_reg_e),
    .reg_write_e     (reg_write_e),
    .mem_to_reg_e    (mem_to_reg_e),
    .write_reg_m     (write_reg_m),
    .reg_write_m     (reg_write_m),
    .write_reg_w     (write_reg_w),
    .reg_write_w     (reg_write_w),
    .branch_resolved (branch_resolved),
    .branch_taken    (branch_taken),
    .stall_f         (stall_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .flush_e         (flush_e),
    .forward_a_e     (forward_a_e),
    .forward_b_e     (forward_b_e),
    .resume          (resume),
    .redirect        (redirect),
    .timeout_err     (timeout_err),
    .stall_count     (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d = 0; rt_d = 0; branch_d = 0;
    rs_e = 0; rt_e = 0; write_reg_e = 0; reg_write_e = 0; mem_to_reg_e = 0;
    write_reg_m = 0; reg_write_m = 0; write_reg_w = 0; reg_write_w = 0;
    branch_resolved = 0; branch_taken = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();

    // Reset: everything quiet even with a forwarding match presented.
    reg_write_m = 1; write_reg_m = 5; rs_e = 5; branch_d = 1;
    #1;
    check_output("rst_fwd_a", 32'(forward_a_e), 0);
    check_output("rst_stall_f", 32'(stall_f), 0);
    check_output("rst_count", stall_count, 0);
    check_output("rst_timeout", 32'(timeout_err), 0);
    clear_inputs();
    rst = 1'b0;
    #1;

    // Forwarding priority and zero-register exclusion.
    reg_write_m = 1; write_reg_m = 5; reg_write_w = 1; write_reg_w = 5; rs_e = 5; rt_e = 5;
    #1;
    check_output("fwd_a_m", 32'(forward_a_e), 2);
    check_output("fwd_b_m", 32'(forward_b_e), 2);
    reg_write_m = 0;
    #1;
    check_output("fwd_a_w", 32'(forward_a_e), 1);
    reg_write_m = 1; write_reg_m = 0; write_reg_w = 0; rs_e = 0;
    #1;
    check_output("fwd_a_zero", 32'(forward_a_e), 0);
    write_reg_m = 3; rs_e = 3; write_reg_w = 7; rt_e = 7;
    #1;
    check_output("fwd_a_m3", 32'(forward_a_e), 2);
    check_output("fwd_b_w7", 32'(forward_b_e), 1);
    clear_inputs();

    // Load destined to $zero is not a hazard.
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 0; rt_d = 0;
    #1;
    check_output("lu_zero", 32'(stall_f), 0);

    // Load-use stall for a single cycle.
    write_reg_e = 8; rt_d = 8;
    #1;
    check_output("lu_stall_f", 32'(stall_f), 1);
    check_output("lu_stall_d", 32'(stall_d), 1);
    check_output("lu_flush_e", 32'(flush_e), 1);
    check_output("lu_flush_d", 32'(flush_d), 0);
    tick();
    clear_inputs();
    #1;
    check_output("lu_after", 32'(stall_f), 0);
    check_output("lu_count", stall_count, 1);

    // Branch not taken, resolved on the third wait cycle.
    branch_d = 1;
    #1;
    check_output("bnt_entry", 32'(stall_f), 0);
    tick();
    branch_d = 0;
    #1;
    check_output("bnt_w1_stall", 32'(stall_f), 1);
    check_output("bnt_w1_flush_d", 32'(flush_d), 1);
    check_output("bnt_w1_resume", 32'(resume), 0);
    tick();
    check_output("bnt_w2_stall", 32'(stall_f), 1);
    tick();
    branch_resolved = 1; branch_taken = 0;
    #1;
    check_output("bnt_w3_resume", 32'(resume), 1);
    check_output("bnt_w3_redirect", 32'(redirect), 0);
    check_output("bnt_w3_stall", 32'(stall_f), 1);
    tick();
    branch_resolved = 0;
    #1;
    check_output("bnt_run_stall", 32'(stall_f), 0);
    check_output("bnt_run_resume", 32'(resume), 0);
    check_output("bnt_run_redirect", 32'(redirect), 0);
    check_output("bnt_count", stall_count, 4);

    // Branch taken: resume, then one FLUSH cycle.
    branch_d = 1;
    tick();
    branch_d = 0; branch_resolved = 1; branch_taken = 1;
    #1;
    check_output("bt_resume", 32'(resume), 1);
    check_output("bt_redirect_early", 32'(redirect), 0);
    tick();
    branch_resolved = 0; branch_taken = 0;
    #1;
    check_output("bt_redirect", 32'(redirect), 1);
    check_output("bt_flush_d", 32'(flush_d), 1);
    check_output("bt_flush_e", 32'(flush_e), 1);
    check_output("bt_stall_f", 32'(stall_f), 0);
    check_output("bt_resume_off", 32'(resume), 0);
    tick();
    check_output("bt_run_redirect", 32'(redirect), 0);
    check_output("bt_run_flush_d", 32'(flush_d), 0);
    check_output("bt_count", stall_count, 5);

    // Resolution outside BRANCH_WAIT is ignored.
    branch_resolved = 1; branch_taken = 1;
    #1;
    check_output("run_resolved_resume", 32'(resume), 0);
    tick();
    check_output("run_resolved_redirect", 32'(redirect), 0);
    check_output("run_resolved_stall", 32'(stall_f), 0);
    branch_resolved = 0; branch_taken = 0;

    // Timeout after eight unresolved wait cycles.
    branch_d = 1;
    tick();
    branch_d = 0;
    for (int i = 1; i <= 7; i++) begin
      #1;
      check_output($sformatf("to_w%0d_resume", i), 32'(resume), 0);
      tick();
    end
    check_output("to_w8_resume", 32'(resume), 1);
    check_output("to_w8_stall", 32'(stall_f), 1);
    check_output("to_w8_err_pre", 32'(timeout_err), 0);
    tick();
    check_output("to_err", 32'(timeout_err), 1);
    check_output("to_run_stall", 32'(stall_f), 0);
    check_output("to_count", stall_count, 13);
    tick();
    tick();
    check_output("to_err_sticky", 32'(timeout_err), 1);

    // Load-use and branch together: stall first, branch entry deferred.
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 8; rt_d = 8; branch_d = 1;
    #1;
    check_output("lub_stall_f", 32'(stall_f), 1);
    check_output("lub_flush_e", 32'(flush_e), 1);
    check_output("lub_flush_d", 32'(flush_d), 0);
    tick();
    mem_to_reg_e = 0; reg_write_e = 0; write_reg_e = 0; rt_d = 0;
    #1;
    check_output("lub_run", 32'(stall_f), 0);
    tick();
    branch_d = 0;
    #1;
    check_output("lub_wait_stall", 32'(stall_f), 1);
    check_output("lub_wait_flush_d", 32'(flush_d), 1);
    tick();
    check_output("lub_count", stall_count, 15);

    // Reset mid-wait: outputs drop at once, no pulses afterwards.
    rst = 1; branch_resolved = 1; branch_taken = 1;
    #1;
    check_output("rstw_stall_f", 32'(stall_f), 0);
    check_output("rstw_flush_d", 32'(flush_d), 0);
    check_output("rstw_resume", 32'(resume), 0);
    tick();
    rst = 0; branch_resolved = 0; branch_taken = 0;
    #1;
    check_output("rstw_err", 32'(timeout_err), 0);
    check_output("rstw_count", stall_count, 0);
    check_output("rstw_run_stall", 32'(stall_f), 0);
    check_output("rstw_run_resume", 32'(resume), 0);
    tick();
    check_output("rstw_run_redirect", 32'(redirect), 0);
    check_output("rstw_run_flush_d", 32'(flush_d), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
